// File: rtl/rpn_evaluator.sv
// Reverse-Polish f(x) sequencer: fetches tokens, keeps an operand stack and issues arithmetic to the shared ALU.
// Optional build macro RPN_EVALUATOR_DIV_POW_EN enables DIV/POW tokens; otherwise they raise the illegal-op error.
module rpn_evaluator #(
  parameter int INTEGER_PART_WIDTH    = 8,
  parameter int FRACTIONAL_PART_WIDTH = 8,
  parameter int STACK_DEPTH           = 8,
  parameter int PROGRAM_ADDR_WIDTH    = 6,
  localparam int N = INTEGER_PART_WIDTH + FRACTIONAL_PART_WIDTH
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          start,
  input  logic [N-1:0]                  x,
  output logic                          busy,
  output logic                          done,
  output logic [2:0]                    error,
  output logic [N-1:0]                  result,
  output logic [PROGRAM_ADDR_WIDTH-1:0] prog_addr,
  input  logic [N+2:0]                  prog_data,
  output logic                          alu_start,
  output logic [2:0]                    alu_op,
  output logic [N-1:0]                  alu_a,
  output logic [N-1:0]                  alu_b,
  input  logic                          alu_done,
  input  logic [N-1:0]                  alu_result,
  output logic [2:0]                    dbg_state
);

  localparam int SPW = $clog2(STACK_DEPTH + 1);
  localparam int IW  = $clog2(STACK_DEPTH);

  localparam logic [2:0] OP_DIV    = 3'd3;
  localparam logic [2:0] OP_POW    = 3'd4;
  localparam logic [2:0] OP_PUSH_C = 3'd5;
  localparam logic [2:0] OP_PUSH_X = 3'd6;
  localparam logic [2:0] OP_END    = 3'd7;

  localparam logic [2:0] ERR_NONE      = 3'd0;
  localparam logic [2:0] ERR_UNDERFLOW = 3'd1;
  localparam logic [2:0] ERR_OVERFLOW  = 3'd2;
  localparam logic [2:0] ERR_BAD_END   = 3'd3;
  localparam logic [2:0] ERR_ILLEGAL   = 3'd4;
  localparam logic [2:0] ERR_OVERRUN   = 3'd5;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_FETCH    = 3'd1,
    S_EXEC     = 3'd2,
    S_ALU_WAIT = 3'd3,
    S_DONE     = 3'd4
  } state_t;

  state_t                          state, state_next;
  logic [SPW-1:0]                  sp;
  logic [PROGRAM_ADDR_WIDTH-1:0]   pc;
  logic [N-1:0]                    x_q;
  logic [N-1:0]                    stack [STACK_DEPTH];

  logic [2:0]    opcode;
  logic [N-1:0]  payload;
  logic          is_arith, is_push, is_end, illegal;
  logic [2:0]    exec_err;
  logic [IW-1:0] top_idx, sec_idx, push_idx;
  logic          alu_accept;
  logic          stack_we;
  logic [N-1:0]  stack_wdata;

  assign opcode   = prog_data[N+2:N];
  assign payload  = prog_data[N-1:0];
  assign is_arith = (opcode <= OP_POW);
  assign is_push  = (opcode == OP_PUSH_C) || (opcode == OP_PUSH_X);
  assign is_end   = (opcode == OP_END);
  assign top_idx  = IW'(sp - SPW'(1));
  assign sec_idx  = IW'(sp - SPW'(2));
  assign push_idx = IW'(sp);
  assign prog_addr = pc;

`ifdef RPN_EVALUATOR_DIV_POW_EN
  assign illegal = 1'b0;
`else
  assign illegal = (opcode == OP_DIV) || (opcode == OP_POW);
`endif

  // ALU handshake: alu_start is a one-cycle command strobe with alu_op/alu_a/alu_b held
  // until completion; alu_done idles high, so it only counts once alu_start has dropped.
  assign alu_accept = (state == S_ALU_WAIT) && !alu_start && alu_done;

  always_comb begin
    exec_err = ERR_NONE;
    if (is_arith && (sp < SPW'(2)))                exec_err = ERR_UNDERFLOW;
    else if (is_push && (sp == SPW'(STACK_DEPTH))) exec_err = ERR_OVERFLOW;
    else if (illegal)                              exec_err = ERR_ILLEGAL;
    else if (!is_end && (pc == '1))                exec_err = ERR_OVERRUN;
    else if (is_end && (sp != SPW'(1)))            exec_err = ERR_BAD_END;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE, S_DONE: if (start) state_next = S_FETCH;
      S_FETCH:        state_next = S_EXEC;
      S_EXEC: begin
        if ((exec_err != ERR_NONE) || is_end) state_next = S_DONE;
        else if (is_push)                     state_next = S_FETCH;
        else                                  state_next = S_ALU_WAIT;
      end
      S_ALU_WAIT:     if (alu_accept) state_next = S_FETCH;
      default:        state_next = S_IDLE;
    endcase
  end

  always_comb begin
    busy      = (state == S_FETCH) || (state == S_EXEC) || (state == S_ALU_WAIT);
    done      = (state == S_DONE);
    dbg_state = state;
  end

  // Both push sources and the ALU write-back land at the current sp (after any pops).
  always_comb begin
    stack_we    = 1'b0;
    stack_wdata = (opcode == OP_PUSH_X) ? x_q : payload;
    if ((state == S_EXEC) && is_push && (exec_err == ERR_NONE)) begin
      stack_we = 1'b1;
    end else if (alu_accept) begin
      stack_we    = 1'b1;
      stack_wdata = alu_result;
    end
  end

  always_ff @(posedge clk) begin
    if (stack_we) stack[push_idx] <= stack_wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc        <= '0;
      sp        <= '0;
      x_q       <= '0;
      error     <= ERR_NONE;
      result    <= '0;
      alu_start <= 1'b0;
      alu_op    <= 3'd0;
      alu_a     <= '0;
      alu_b     <= '0;
    end else begin
      alu_start <= 1'b0;
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            x_q    <= x;
            pc     <= '0;
            sp     <= '0;
            error  <= ERR_NONE;
            result <= '0;
          end
        end
        S_EXEC: begin
          if (exec_err != ERR_NONE) begin
            error  <= exec_err;
            result <= '0;
          end else if (is_end) begin
            result <= stack[top_idx];
          end else if (is_push) begin
            sp <= sp + SPW'(1);
            pc <= pc + PROGRAM_ADDR_WIDTH'(1);
          end else begin
            alu_op    <= opcode;
            alu_a     <= stack[sec_idx];
            alu_b     <= stack[top_idx];
            alu_start <= 1'b1;
            sp        <= sp - SPW'(2);
          end
        end
        S_ALU_WAIT: begin
          if (alu_accept) begin
            sp <= sp + SPW'(1);
            pc <= pc + PROGRAM_ADDR_WIDTH'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_rpn_evaluator.sv
// Bench for rpn_evaluator: program memory and ALU models, queue-based RPN reference, directed and random programs.
module tb_rpn_evaluator;
  localparam int FW = 8;
  localparam int N  = 16;
  localparam int D  = 8;
  localparam int AW = 6;
  localparam int W  = 3 + 2 * N;

`ifdef RPN_EVALUATOR_DIV_POW_EN
  localparam bit DIV_EN = 1'b1;
`else
  localparam bit DIV_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n, start;
  logic [N-1:0]  x;
  logic          busy, done;
  logic [2:0]    error;
  logic [N-1:0]  result;
  logic [AW-1:0] prog_addr;
  logic [N+2:0]  prog_data = '0;
  logic          alu_start;
  logic [2:0]    alu_op;
  logic [N-1:0]  alu_a, alu_b;
  logic          alu_done;
  logic [N-1:0]  alu_result;
  logic [2:0]    dbg_state;

  rpn_evaluator dut (
    .clk(clk), .rst_n(rst_n), .start(start), .x(x), .busy(busy), .done(done),
    .error(error), .result(result), .prog_addr(prog_addr), .prog_data(prog_data),
    .alu_start(alu_start), .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b),
    .alu_done(alu_done), .alu_result(alu_result), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Fixed-point ALU behaviour, shared by the ALU model and the reference.
  function automatic logic [N-1:0] alu_fn(input logic [2:0] op, input logic [N-1:0] a, input logic [N-1:0] b);
    logic signed [31:0] sa, sb, r;
    sa = {{(32-N){a[N-1]}}, a};
    sb = {{(32-N){b[N-1]}}, b};
    case (op)
      3'd0:    r = sa + sb;
      3'd1:    r = sa - sb;
      3'd2:    r = (sa * sb) >>> FW;
      3'd3:    r = (sb == 0) ? -32'sd1 : (sa <<< FW) / sb;
      default: r = (sa * sa) >>> FW;
    endcase
    return r[N-1:0];
  endfunction

  function automatic int alu_lat(input logic [2:0] op);
    if (op <= 3'd1) return 1;
    if (op == 3'd2) return 3;
    return 5;
  endfunction

  function automatic logic [N+2:0] tk(input logic [2:0] op, input logic [N-1:0] p);
    return {op, p};
  endfunction

  logic [N+2:0] prog [64];
  always @(posedge clk) prog_data <= prog[prog_addr];

  int           alu_cnt;
  logic         alu_pend;
  logic [2:0]   p_op;
  logic [N-1:0] p_a, p_b;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_done <= 1'b1; alu_cnt <= 0; alu_result <= '0; alu_pend <= 1'b0;
    end else if (alu_start) begin
      alu_done <= 1'b0; alu_cnt <= alu_lat(alu_op); alu_pend <= 1'b1;
      p_op <= alu_op; p_a <= alu_a; p_b <= alu_b;
    end else if (alu_cnt > 1) begin
      alu_cnt <= alu_cnt - 1;
    end else if (alu_cnt == 1) begin
      alu_result <= alu_fn(p_op, p_a, p_b); alu_done <= 1'b1; alu_cnt <= 0; alu_pend <= 1'b0;
    end
  end

  logic [W-1:0] exp_q[$];
  logic [W-1:0] got_q[$];
  int   viol = 0;
  logic start_prev = 1'b0;
  always @(negedge clk) begin
    if (alu_start) got_q.push_back({alu_op, alu_a, alu_b});
    if (alu_start && start_prev) viol++;
    if (alu_pend && ({alu_op, alu_a, alu_b} !== {p_op, p_a, p_b})) viol++;
    start_prev = alu_start;
  end

  // Reference: walks the program with a plain queue as the operand stack.
  task automatic ref_eval(input logic [N-1:0] xv, output logic [2:0] err, output logic [N-1:0] res, output int cyc);
    logic [N-1:0] st[$];
    logic [N-1:0] a, b, pl;
    logic [2:0]   op;
    exp_q.delete();
    err = 3'd0; res = '0; cyc = 0;
    for (int pc = 0; pc < 64; pc++) begin
      op = prog[pc][N+2:N];
      pl = prog[pc][N-1:0];
      cyc += 2;
      if (op == 3'd7) begin
        if (st.size() == 1) res = st[0];
        else err = 3'd3;
        break;
      end
      if (op <= 3'd4) begin
        if (st.size() < 2) err = 3'd1;
        else if (!DIV_EN && op >= 3'd3) err = 3'd4;
        else if (pc == 63) err = 3'd5;
        else begin
          b = st.pop_back();
          a = st.pop_back();
          exp_q.push_back({op, a, b});
          st.push_back(alu_fn(op, a, b));
          cyc += 2 + alu_lat(op);
        end
      end else begin
        if (st.size() == D) err = 3'd2;
        else if (pc == 63) err = 3'd5;
        else st.push_back((op == 3'd5) ? pl : xv);
      end
      if (err != 3'd0) break;
    end
  endtask

  task automatic clear_prog();
    for (int i = 0; i < 64; i++) prog[i] = tk(3'd7, '0);
  endtask

  logic [2:0]   last_err;
  logic [N-1:0] last_result, last_exp_res;
  int           last_cyc;

  task automatic run_prog(input string tag, input logic [N-1:0] xv, input bit hold);
    logic [2:0]   e_err;
    logic [N-1:0] e_res;
    int           e_cyc, cyc, v0, n;
    ref_eval(xv, e_err, e_res, e_cyc);
    got_q.delete();
    v0 = viol;
    @(negedge clk); x = xv; start = 1'b1;
    @(posedge clk); #1;
    if (!hold) start = 1'b0;
    check({tag, "_busy"}, busy, 1);
    cyc = 0;
    while (!done && cyc < 3000) begin
      @(posedge clk); #1; cyc++;
    end
    check({tag, "_done"}, done, 1);
    check({tag, "_idle"}, busy, 0);
    check({tag, "_cycles"}, cyc, e_cyc);
    check({tag, "_error"}, error, e_err);
    check({tag, "_result"}, result, e_res);
    check({tag, "_alu_cmds"}, got_q.size(), exp_q.size());
    n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) check({tag, "_alu_cmd"}, got_q[i], exp_q[i]);
    check({tag, "_alu_hold"}, viol - v0, 0);
    last_err = error; last_result = result; last_cyc = cyc; last_exp_res = e_res;
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_error"}, error, 0);
    check({tag, "_result"}, result, 0);
    check({tag, "_prog_addr"}, prog_addr, 0);
    check({tag, "_alu_start"}, alu_start, 0);
    check({tag, "_alu_op"}, alu_op, 0);
    check({tag, "_alu_a"}, alu_a, 0);
    check({tag, "_alu_b"}, alu_b, 0);
  endtask

  task automatic gen_random();
    int len, depth, r;
    clear_prog();
    len = $urandom_range(1, 24);
    depth = 0;
    for (int i = 0; i < len; i++) begin
      r = $urandom_range(0, 99);
      if (r < 6) begin
        prog[i] = tk(3'($urandom_range(0, 7)), 16'($urandom));
      end else if (depth < 2 || (depth < D && r < 55)) begin
        prog[i] = tk(r[0] ? 3'd5 : 3'd6, 16'($urandom));
        depth++;
      end else begin
        prog[i] = tk(3'($urandom_range(0, 2)), '0);
        depth--;
      end
    end
  endtask

  initial begin
    int cyc;
    rst_n = 1'b0; start = 1'b0; x = '0;
    clear_prog();
    repeat (3) @(posedge clk);
    #1;
    check_reset("reset");
    @(negedge clk); rst_n = 1'b1;

    prog[0] = tk(3'd6, '0); prog[1] = tk(3'd5, 16'h0200); prog[2] = tk(3'd0, '0);
    run_prog("add", 16'h0300, 1'b0);
    check("add_value", last_result, 16'h0500);

    clear_prog();
    prog[0] = tk(3'd5, 16'h0100); prog[1] = tk(3'd6, '0); prog[2] = tk(3'd1, '0);
    run_prog("sub", 16'h0400, 1'b0);
    check("sub_value", last_result, 16'hFD00);

    clear_prog();
    prog[0] = tk(3'd0, '0);
    run_prog("underflow", 16'h0100, 1'b0);
    check("underflow_code", last_err, 3'd1);

    clear_prog();
    for (int i = 0; i <= D; i++) prog[i] = tk(3'd5, 16'(i));
    run_prog("overflow", 16'h0100, 1'b0);
    check("overflow_code", last_err, 3'd2);

    clear_prog();
    prog[0] = tk(3'd6, '0); prog[1] = tk(3'd6, '0);
    run_prog("bad_end", 16'h0700, 1'b0);
    check("bad_end_code", last_err, 3'd3);

    clear_prog();
    prog[0] = tk(3'd5, 16'h0300); prog[1] = tk(3'd5, 16'h0200); prog[2] = tk(3'd3, '0);
    run_prog("div", 16'h0000, 1'b0);

    clear_prog();
    prog[0] = tk(3'd6, '0);
    for (int i = 1; i < 63; i += 2) begin
      prog[i] = tk(3'd6, '0); prog[i+1] = tk(3'd0, '0);
    end
    prog[63] = tk(3'd6, '0);
    run_prog("overrun", 16'h0001, 1'b0);
    check("overrun_code", last_err, 3'd5);

    clear_prog();
    prog[0] = tk(3'd6, '0); prog[1] = tk(3'd6, '0); prog[2] = tk(3'd2, '0);
    @(negedge clk); x = 16'h0180; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    cyc = 0;
    while (!alu_pend && cyc < 200) begin
      @(posedge clk); #1; cyc++;
    end
    check("abort_reached_alu", alu_pend, 1);
    @(negedge clk); rst_n = 1'b0;
    #1;
    check_reset("abort");
    @(negedge clk); rst_n = 1'b1;

    clear_prog();
    prog[0] = tk(3'd6, '0);
    run_prog("after_abort", 16'h1234, 1'b0);
    check("latency_push_end", last_cyc, 4);
    check("after_abort_value", last_result, 16'h1234);

    clear_prog();
    prog[0] = tk(3'd6, '0); prog[1] = tk(3'd6, '0); prog[2] = tk(3'd2, '0);
    run_prog("held_start", 16'h0280, 1'b1);
    @(posedge clk); #1;
    check("restart_busy", busy, 1);
    check("restart_done", done, 0);
    start = 1'b0;
    cyc = 0;
    while (!done && cyc < 3000) begin
      @(posedge clk); #1; cyc++;
    end
    check("restart_finished", done, 1);
    check("restart_result", result, last_exp_res);

    for (int t = 0; t < 40; t++) begin
      gen_random();
      run_prog("random", 16'($urandom), 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
